// File: rtl/avrpp_pkg.sv
// Shared op codes, sequencer state encoding, select bit positions and the command struct.
package avrpp_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_PAGEL = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT_RDY,
        ST_DONE
    } state_t;

    // Bit positions inside cmd_sel = {bs2, bs1, xa1, xa0}
    localparam int SEL_XA0 = 0;
    localparam int SEL_XA1 = 1;
    localparam int SEL_BS1 = 2;
    localparam int SEL_BS2 = 3;

    typedef struct packed {
        op_t        op;
        logic [3:0] sel;
    } cmd_t;

    // Bits needed to hold a down-counter start value of max_load
    function automatic int tick_width(input int max_load);
        return (max_load < 1) ? 1 : $clog2(max_load + 1);
    endfunction

endpackage

// File: rtl/avrpp_seq_if.sv
// Host-side command/response bus of the HV programming sequencer.
interface avrpp_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_sel;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/avrpp_tick.sv
// Loadable down-counter; done is high while the count sits at zero, so a load of N-1 spans N cycles.
module avrpp_tick #(
    parameter int W = 3
) (
    input  logic         osc,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/avrpp_seq.sv
// ATmega8 HV parallel-programming strobe sequencer: accept -> rsp_valid in 3*HALF_TICKS+1 cycles (+RDY wait on WRITE);
// cmd_ready is low for the whole command. Define AVRPP_TIMEOUT_EN to bound the RDY wait and flag rsp_err.
module avrpp_seq
    import avrpp_pkg::*;
#(
    parameter int HALF_TICKS  = 4,
    parameter int RDY_TIMEOUT = 65535
) (
    input  logic       osc,
    input  logic       rst_n,
    avrpp_seq_if.slave bus,
    input  logic [7:0] dut_q,
    input  logic       dut_rdy,
    output logic [7:0] dut_data,
    output logic       dut_data_oe,
    output logic       dut_oe_n,
    output logic       dut_wr_n,
    output logic       dut_xtal,
    output logic       dut_pagel,
    output logic       dut_bs1,
    output logic       dut_bs2,
    output logic       dut_xa0,
    output logic       dut_xa1
);

`ifdef AVRPP_TIMEOUT_EN
    localparam int TICK_W = tick_width(((HALF_TICKS > RDY_TIMEOUT) ? HALF_TICKS : RDY_TIMEOUT) - 1);
    localparam logic [TICK_W-1:0] WAIT_LOAD = TICK_W'(RDY_TIMEOUT - 1);
`else
    localparam int TICK_W = tick_width(HALF_TICKS - 1);
`endif
    localparam logic [TICK_W-1:0] PHASE_LOAD = TICK_W'(HALF_TICKS - 1);

    if (HALF_TICKS < 1 || RDY_TIMEOUT < 1) begin : g_param_check
        $error("avrpp_seq: HALF_TICKS and RDY_TIMEOUT must be at least 1");
    end

    state_t            state, state_nxt;
    cmd_t              cmd_q;
    logic [7:0]        data_q;
    logic              data_oe_q;
    logic [7:0]        rsp_data_q;
    logic              accept;
    logic              tick_load, tick_done;
    logic [TICK_W-1:0] tick_val;
    logic              rdy_meta, rdy_sync;
    logic              read_window;

    assign accept        = bus.cmd_valid && (state == ST_IDLE);
    assign bus.cmd_ready = (state == ST_IDLE);

    avrpp_tick #(.W(TICK_W)) u_tick (
        .osc      (osc),
        .rst_n    (rst_n),
        .load     (tick_load),
        .load_val (tick_val),
        .done     (tick_done)
    );

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_load = 1'b0;
        tick_val  = PHASE_LOAD;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                    tick_load = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick_done) begin
                    state_nxt = ST_PULSE;
                    tick_load = 1'b1;
                end
            end
            ST_PULSE: begin
                if (tick_done) begin
                    state_nxt = ST_HOLD;
                    tick_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tick_done) begin
                    if (cmd_q.op == OP_WRITE) begin
                        state_nxt = ST_WAIT_RDY;
                        tick_load = 1'b1;
`ifdef AVRPP_TIMEOUT_EN
                        tick_val  = WAIT_LOAD;
`endif
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT_RDY: begin
                if (rdy_sync) begin
                    state_nxt = ST_DONE;
                end
`ifdef AVRPP_TIMEOUT_EN
                else if (tick_done) begin
                    state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // /OE is gated by the registered bus-drive enable so the two can never overlap
    assign read_window = (cmd_q.op == OP_READ) && !data_oe_q &&
                         ((state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD));

    always_comb begin
        dut_oe_n      = !read_window;
        dut_wr_n      = 1'b1;
        dut_xtal      = 1'b0;
        dut_pagel     = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_PULSE: begin
                dut_xtal  = (cmd_q.op == OP_LOAD);
                dut_wr_n  = (cmd_q.op != OP_WRITE);
                dut_pagel = (cmd_q.op == OP_PAGEL);
            end
            ST_DONE: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            data_q     <= 8'h00;
            data_oe_q  <= 1'b0;
            rsp_data_q <= 8'h00;
        end else begin
            if (accept) begin
                cmd_q      <= '{op: op_t'(bus.cmd_op), sel: bus.cmd_sel};
                rsp_data_q <= 8'h00;
                case (op_t'(bus.cmd_op))
                    OP_LOAD: begin
                        data_q    <= bus.cmd_data;
                        data_oe_q <= 1'b1;
                    end
                    OP_READ: data_oe_q <= 1'b0;
                    default: ;
                endcase
            end
            if (state == ST_HOLD && tick_done && cmd_q.op == OP_READ) begin
                rsp_data_q <= dut_q;
            end
        end
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            rdy_meta <= 1'b0;
            rdy_sync <= 1'b0;
        end else begin
            rdy_meta <= dut_rdy;
            rdy_sync <= rdy_meta;
        end
    end

`ifdef AVRPP_TIMEOUT_EN
    logic rsp_err_q;

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (accept) begin
            rsp_err_q <= 1'b0;
        end else if (state == ST_WAIT_RDY && !rdy_sync && tick_done) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.rsp_data = rsp_data_q;
    assign dut_data     = data_q;
    assign dut_data_oe  = data_oe_q;
    // Mode selects stay on the pins after DONE; the DUT latches BS/XA levels asynchronously
    assign dut_bs2      = cmd_q.sel[SEL_BS2];
    assign dut_bs1      = cmd_q.sel[SEL_BS1];
    assign dut_xa1      = cmd_q.sel[SEL_XA1];
    assign dut_xa0      = cmd_q.sel[SEL_XA0];

endmodule

// File: tb/tb_avrpp_seq.sv
// Randomised bench for avrpp_seq with a cycle-timeline reference model built from the phase rules.
module tb_avrpp_seq;

    localparam int H   = 4;
    localparam int RTO = 50;
    localparam int CAP = 160;
    localparam logic [1:0] LOAD = 2'd0, WRITE = 2'd1, READ = 2'd2, PAGEL = 2'd3;

    logic       osc = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dut_q, dut_data;
    logic       dut_rdy, dut_data_oe, dut_oe_n, dut_wr_n, dut_xtal, dut_pagel;
    logic       dut_bs1, dut_bs2, dut_xa0, dut_xa1;
    logic [7:0] rd_byte = 8'h00;

    avrpp_seq_if bus_if();

    avrpp_seq #(.HALF_TICKS(H), .RDY_TIMEOUT(RTO)) dut (
        .osc(osc), .rst_n(rst_n), .bus(bus_if),
        .dut_q(dut_q), .dut_rdy(dut_rdy), .dut_data(dut_data), .dut_data_oe(dut_data_oe),
        .dut_oe_n(dut_oe_n), .dut_wr_n(dut_wr_n), .dut_xtal(dut_xtal), .dut_pagel(dut_pagel),
        .dut_bs1(dut_bs1), .dut_bs2(dut_bs2), .dut_xa0(dut_xa0), .dut_xa1(dut_xa1)
    );

    always #5 osc = ~osc;

    // Target chip only drives its data pins while /OE is low
    assign dut_q = dut_oe_n ? 8'h00 : rd_byte;

    int cyc = 0;
    always @(posedge osc) cyc++;

    int vectors = 0;
    int fails = 0;

    logic [27:0] cap_vec [CAP];
    int          cap_n, acc_cyc;
    bit          acc_ok;
    logic        m_doe = 1'b0;
    logic [7:0]  m_data = 8'h00;
    logic [1:0]  b_op;
    logic [3:0]  b_sel;
    logic [7:0]  b_data;

    function automatic logic [27:0] cur_vec();
        return {bus_if.cmd_ready, bus_if.rsp_valid, bus_if.rsp_err,
                dut_oe_n, dut_wr_n, dut_xtal, dut_pagel, dut_data_oe,
                dut_bs2, dut_bs1, dut_xa1, dut_xa0, bus_if.rsp_data, dut_data};
    endfunction

    // Cycle (relative to the accept cycle) at which rsp_valid is due; RDY is pulled low when /WR is first seen low
    function automatic int model_done(input logic [1:0] op, input int rdy_low, output bit err);
        int kd;
        err = 1'b0;
        if (op != WRITE) return 3*H + 1;
        kd = 3*H + 2;
        if (rdy_low > 0 && (H + 1 + rdy_low + 3) > kd) kd = H + 1 + rdy_low + 3;
`ifdef AVRPP_TIMEOUT_EN
        if (kd > 3*H + 1 + RTO) begin
            kd  = 3*H + 1 + RTO;
            err = 1'b1;
        end
`endif
        return kd;
    endfunction

    function automatic logic [27:0] exp_vec(input logic [1:0] op, input logic [3:0] sel, input int k,
                                            input int kd, input bit err, input logic doe,
                                            input logic [7:0] rb, input logic [7:0] dd);
        bit         pulse;
        logic [7:0] rd;
        pulse = (k > H) && (k <= 2*H);
        rd    = (op == READ && k > 3*H) ? rb : 8'h00;
        return {k > kd, k == kd, err && (k >= kd),
                !(op == READ && k <= 3*H), !(op == WRITE && pulse), op == LOAD && pulse, op == PAGEL && pulse,
                doe, sel, rd, dd};
    endfunction

    task automatic model_accept(input logic [1:0] op, input logic [7:0] data);
        if (op == LOAD) begin
            m_doe  = 1'b1;
            m_data = data;
        end else if (op == READ) begin
            m_doe = 1'b0;
        end
    endtask

    // Drives one command from a negedge and records outputs each cycle until the cycle after rsp_valid
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] sel, input logic [7:0] data,
                           input int rdy_low, input bit hold_valid);
        int w, wr_k, rise_k, rv_k;
        dut_rdy          = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_sel   = sel;
        bus_if.cmd_data  = data;
        w = 0;
        while (bus_if.cmd_ready !== 1'b1 && w < 200) begin
            @(negedge osc);
            w++;
        end
        acc_ok  = (bus_if.cmd_ready === 1'b1);
        acc_cyc = cyc;
        wr_k = -1; rise_k = -1; rv_k = -1; cap_n = CAP - 1;
        for (int k = 1; k < CAP; k++) begin
            @(negedge osc);
            if (k == 1) begin
                if (hold_valid) begin
                    bus_if.cmd_op   = b_op;
                    bus_if.cmd_sel  = b_sel;
                    bus_if.cmd_data = b_data;
                end else begin
                    bus_if.cmd_valid = 1'b0;
                end
            end
            cap_vec[k] = cur_vec();
            if (rdy_low > 0 && wr_k < 0 && dut_wr_n === 1'b0) begin
                wr_k    = k;
                rise_k  = k + rdy_low;
                dut_rdy = 1'b0;
            end
            if (k == rise_k) dut_rdy = 1'b1;
            if (bus_if.rsp_valid === 1'b1 && rv_k < 0) rv_k = k;
            if (rv_k >= 0 && k == rv_k + 1) begin
                cap_n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [27:0] want;
        want = {1'b1, 1'b0, 1'b0, 4'b1100, 1'b0, 4'h0, 8'h00, 8'h00};
        repeat (2) @(negedge osc);
        vectors++;
        if (cur_vec() !== want) begin
            fails++;
            $display("FAIL reset_hold got=%h want=%h", cur_vec(), want);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge osc);
        vectors++;
        if (cur_vec() !== want) begin
            fails++;
            $display("FAIL reset_idle got=%h want=%h", cur_vec(), want);
        end
    endtask

    task automatic test_load();
        logic [3:0] sel;
        logic [7:0] data;
        logic [27:0] e;
        int kd;
        bit err;
        for (int n = 0; n < 4; n++) begin
            sel  = (n == 0) ? 4'b0001 : 4'($urandom_range(0, 15));
            data = (n == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            run_cmd(LOAD, sel, data, 0, 1'b0);
            model_accept(LOAD, data);
            kd = model_done(LOAD, 0, err);
            vectors++;
            if (!acc_ok) begin fails++; $display("FAIL load_accept got=0 want=1"); end
            for (int k = 1; k <= cap_n; k++) begin
                e = exp_vec(LOAD, sel, k, kd, err, m_doe, rd_byte, m_data);
                vectors++;
                if (cap_vec[k] !== e) begin
                    fails++;
                    $display("FAIL load k=%0d got=%h want=%h", k, cap_vec[k], e);
                end
            end
        end
    endtask

    task automatic test_read();
        logic [3:0] sel;
        logic [27:0] e;
        int kd;
        bit err;
        for (int n = 0; n < 4; n++) begin
            sel     = (n == 0) ? 4'b0100 : 4'($urandom_range(0, 15));
            rd_byte = (n == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            run_cmd(READ, sel, 8'($urandom_range(0, 255)), 0, 1'b0);
            model_accept(READ, 8'h00);
            kd = model_done(READ, 0, err);
            vectors++;
            if (!acc_ok) begin fails++; $display("FAIL read_accept got=0 want=1"); end
            for (int k = 1; k <= cap_n; k++) begin
                e = exp_vec(READ, sel, k, kd, err, m_doe, rd_byte, m_data);
                vectors++;
                if (cap_vec[k] !== e) begin
                    fails++;
                    $display("FAIL read k=%0d got=%h want=%h", k, cap_vec[k], e);
                end
            end
        end
    endtask

    task automatic test_write();
        logic [3:0] sel;
        logic [27:0] e;
        int kd;
        bit err;
        sel = 4'($urandom_range(0, 15));
        run_cmd(WRITE, sel, 8'h00, 100, 1'b0);
        kd = model_done(WRITE, 100, err);
        vectors++;
        if (!acc_ok) begin fails++; $display("FAIL write_accept got=0 want=1"); end
        for (int k = 1; k <= cap_n; k++) begin
            e = exp_vec(WRITE, sel, k, kd, err, m_doe, rd_byte, m_data);
            vectors++;
            if (cap_vec[k] !== e) begin
                fails++;
                $display("FAIL write_rdy k=%0d got=%h want=%h", k, cap_vec[k], e);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [3:0] sel;
        logic [7:0] data;
        logic [27:0] e;
        int rl, kd;
        bit err;
        for (int n = 0; n < 30; n++) begin
            op      = 2'($urandom_range(0, 3));
            sel     = 4'($urandom_range(0, 15));
            data    = 8'($urandom_range(0, 255));
            rd_byte = 8'($urandom_range(0, 255));
            rl      = (op == WRITE) ? int'($urandom_range(0, 30)) : 0;
            run_cmd(op, sel, data, rl, 1'b0);
            model_accept(op, data);
            kd = model_done(op, rl, err);
            vectors++;
            if (!acc_ok) begin fails++; $display("FAIL random_accept n=%0d got=0 want=1", n); end
            for (int k = 1; k <= cap_n; k++) begin
                e = exp_vec(op, sel, k, kd, err, m_doe, rd_byte, m_data);
                vectors++;
                if (cap_vec[k] !== e) begin
                    fails++;
                    $display("FAIL random n=%0d op=%0d k=%0d got=%h want=%h", n, op, k, cap_vec[k], e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op1;
        logic [3:0] sel1;
        logic [7:0] d1;
        logic [27:0] e;
        int kd1, kd2, a1, rl1;
        bit err;
        for (int n = 0; n < 2; n++) begin
            op1  = (n == 0) ? LOAD : WRITE;
            rl1  = (n == 0) ? 0 : 10;
            sel1 = 4'($urandom_range(0, 15));
            d1   = 8'($urandom_range(0, 255));
            b_op   = (n == 0) ? READ : PAGEL;
            b_sel  = 4'($urandom_range(0, 15));
            b_data = 8'($urandom_range(0, 255));
            rd_byte = 8'($urandom_range(0, 255));
            run_cmd(op1, sel1, d1, rl1, 1'b1);
            a1 = acc_cyc;
            model_accept(op1, d1);
            kd1 = model_done(op1, rl1, err);
            for (int k = 1; k <= cap_n; k++) begin
                e = exp_vec(op1, sel1, k, kd1, err, m_doe, rd_byte, m_data);
                vectors++;
                if (cap_vec[k] !== e) begin
                    fails++;
                    $display("FAIL b2b_first n=%0d k=%0d got=%h want=%h", n, k, cap_vec[k], e);
                end
            end
            run_cmd(b_op, b_sel, b_data, 0, 1'b0);
            vectors++;
            if (acc_cyc - a1 !== kd1 + 1) begin
                fails++;
                $display("FAIL b2b_gap n=%0d got=%0d want=%0d", n, acc_cyc - a1, kd1 + 1);
            end
            model_accept(b_op, b_data);
            kd2 = model_done(b_op, 0, err);
            for (int k = 1; k <= cap_n; k++) begin
                e = exp_vec(b_op, b_sel, k, kd2, err, m_doe, rd_byte, m_data);
                vectors++;
                if (cap_vec[k] !== e) begin
                    fails++;
                    $display("FAIL b2b_second n=%0d k=%0d got=%h want=%h", n, k, cap_vec[k], e);
                end
            end
        end
    endtask

`ifdef AVRPP_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] sel;
        logic [7:0] data;
        logic [27:0] e;
        int kd;
        bit err;
        sel = 4'($urandom_range(0, 15));
        run_cmd(WRITE, sel, 8'h00, 1000, 1'b0);
        kd = model_done(WRITE, 1000, err);
        for (int k = 1; k <= cap_n; k++) begin
            e = exp_vec(WRITE, sel, k, kd, err, m_doe, rd_byte, m_data);
            vectors++;
            if (cap_vec[k] !== e) begin
                fails++;
                $display("FAIL timeout k=%0d got=%h want=%h", k, cap_vec[k], e);
            end
        end
        data = 8'($urandom_range(0, 255));
        run_cmd(LOAD, sel, data, 0, 1'b0);
        model_accept(LOAD, data);
        kd = model_done(LOAD, 0, err);
        for (int k = 1; k <= cap_n; k++) begin
            e = exp_vec(LOAD, sel, k, kd, err, m_doe, rd_byte, m_data);
            vectors++;
            if (cap_vec[k] !== e) begin
                fails++;
                $display("FAIL timeout_clear k=%0d got=%h want=%h", k, cap_vec[k], e);
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        int  w;
        bit  seen;
        dut_rdy          = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = WRITE;
        bus_if.cmd_sel   = 4'($urandom_range(0, 15));
        bus_if.cmd_data  = 8'h00;
        w = 0;
        while (bus_if.cmd_ready !== 1'b1 && w < 200) begin
            @(negedge osc);
            w++;
        end
        @(negedge osc);
        bus_if.cmd_valid = 1'b0;
        repeat (H + 1) @(negedge osc);
        vectors++;
        if (dut_wr_n !== 1'b0) begin
            fails++;
            $display("FAIL arst_pulse_wr_n got=%b want=0", dut_wr_n);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({dut_wr_n, dut_xtal, dut_oe_n, dut_pagel, bus_if.cmd_ready, bus_if.rsp_valid} !== 6'b101010) begin
            fails++;
            $display("FAIL arst_immediate got=%b want=101010",
                     {dut_wr_n, dut_xtal, dut_oe_n, dut_pagel, bus_if.cmd_ready, bus_if.rsp_valid});
        end
        @(negedge osc);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge osc);
            if (bus_if.rsp_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            fails++;
            $display("FAIL arst_no_rsp got=1 want=0");
        end
        m_doe  = 1'b0;
        m_data = 8'h00;
    endtask

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'd0;
        bus_if.cmd_sel   = 4'h0;
        bus_if.cmd_data  = 8'h00;
        dut_rdy          = 1'b1;
        test_reset();
        test_load();
        test_read();
        test_write();
        test_back_to_back();
`ifdef AVRPP_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_async_reset();
        test_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
